// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract, one WIDTH/STAGES-bit carry-chained slice per stage, valid/ready handshake.
// Build option ADDSUB_SAT_EN: ops 10/11 clamp signed overflow to the signed max/min in the final stage.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             out_sat
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic advance;

  // Inputs seen by each stage: entry ports for stage 0, previous stage registers otherwise.
  logic [WIDTH-1:0] a_s   [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             c_s   [STAGES];
  logic             v_s   [STAGES];
  logic             sat_s [STAGES];
  logic [TAG_W-1:0] tag_s [STAGES];

  // Stage results before registering.
  logic [WIDTH-1:0] r_n  [STAGES];
  logic             cy_n [STAGES];

  // Inter-stage registers; the last stage registers straight into out_*.
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] r_p   [STAGES];
  logic             cy_p  [STAGES];
  logic             vld_p [STAGES];
  logic             sat_p [STAGES];
  logic [TAG_W-1:0] tag_p [STAGES];

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0]      slice;
    logic [WIDTH-1:0] rsum;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1: B inverted here, the +1 enters as the stage-0 carry.
      assign a_s[k]   = in_a;
      assign b_s[k]   = in_op[0] ? ~in_b : in_b;
      assign c_s[k]   = in_op[0];
      assign r_s[k]   = '0;
      assign v_s[k]   = in_valid;
      assign sat_s[k] = in_op[1];
      assign tag_s[k] = in_tag;
    end else begin : g_next
      assign a_s[k]   = a_p[k-1];
      assign b_s[k]   = b_p[k-1];
      assign c_s[k]   = cy_p[k-1];
      assign r_s[k]   = r_p[k-1];
      assign v_s[k]   = vld_p[k-1];
      assign sat_s[k] = sat_p[k-1];
      assign tag_s[k] = tag_p[k-1];
    end

    assign slice = {1'b0, a_s[k][k*SW +: SW]} + {1'b0, b_s[k][k*SW +: SW]} + (SW+1)'(c_s[k]);

    always_comb begin
      rsum = r_s[k];
      rsum[k*SW +: SW] = slice[SW-1:0];
    end

    assign r_n[k]  = rsum;
    assign cy_n[k] = slice[SW];
  end

  // Final stage: flags on the wrapped sum, then optional clamp.
  logic [WIDTH-1:0] res_w;
  logic [WIDTH-1:0] data_w;
  logic             co_w;
  logic             ovf_w;
  logic             clamp_w;
  logic [3:0]       flags_w;

  assign res_w   = r_n[L];
  assign co_w    = cy_n[L];
  // Carry into the MSB is recovered as a^b^sum at that bit, avoiding a split MSB adder.
  assign ovf_w   = a_s[L][WIDTH-1] ^ b_s[L][WIDTH-1] ^ res_w[WIDTH-1] ^ co_w;
  assign flags_w = {~|res_w, res_w[WIDTH-1], co_w, ovf_w};

`ifdef ADDSUB_SAT_EN
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [WIDTH-1:0] wrapped);
    // A negative wrapped result means the true result overflowed upward.
    sat_clamp = wrapped[WIDTH-1] ? SMAX : SMIN;
  endfunction

  assign clamp_w = sat_s[L] & ovf_w;
  assign data_w  = clamp_w ? sat_clamp(res_w) : res_w;
`else
  logic unused_sat;
  assign unused_sat = sat_s[L];
  assign clamp_w    = 1'b0;
  assign data_w     = res_w;
`endif

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES - 1; k++) vld_p[k] <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_flags <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) vld_p[k] <= v_s[k];
      out_valid <= v_s[L];
      out_data  <= data_w;
      out_tag   <= tag_s[L];
      out_flags <= flags_w;
      out_sat   <= clamp_w;
    end
  end

  // Inter-stage data and skew registers.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_p[k]   <= a_s[k];
        b_p[k]   <= b_s[k];
        r_p[k]   <= r_n[k];
        cy_p[k]  <= cy_n[k];
        sat_p[k] <= sat_s[k];
        tag_p[k] <= tag_s[k];
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (WIDTH=32, STAGES=4, TAG_W=4).
// Expectations for ops 10/11 follow whether ADDSUB_SAT_EN is defined for the build.
module tb_addsub_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 4;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;
  logic             out_sat;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] d;
    logic [3:0]  f;
    logic        s;
  } vec_t;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_flags(out_flags), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issues one op and waits (bounded) for its result; the caller does the comparisons.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output logic [31:0] d, output logic [3:0] f,
                        output logic [3:0] t, output logic s, output int lat, output logic rdy);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = ~op; in_tag = ~tag;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = out_data; f = out_flags; t = out_tag; s = out_sat;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    checks++; if (out_flags !== 4'h0) begin failures++; $display("FAIL reset_flags: got %b want 0000", out_flags); end
    checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b want 0", out_sat); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    vec_t tv [6] = '{
      '{2'b01, 32'h00000EFF, 32'h00000234, 4'h3, 32'h00000CCB, 4'b0010, 1'b0},
      '{2'b01, 32'h12345678, 32'h12345678, 4'h5, 32'h00000000, 4'b1010, 1'b0},
      '{2'b00, 32'hFFFFFFFF, 32'h00000001, 4'h6, 32'h00000000, 4'b1010, 1'b0},
      '{2'b01, 32'h00000000, 32'h00000001, 4'h7, 32'hFFFFFFFF, 4'b0100, 1'b0},
      '{2'b00, 32'h00FFFFFF, 32'h00000001, 4'h8, 32'h01000000, 4'b0000, 1'b0},
      '{2'b10, 32'h00000005, 32'h00000003, 4'h9, 32'h00000008, 4'b0000, 1'b0}
    };
    logic [31:0] d; logic [3:0] f, t; logic s, rdy; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].tag, d, f, t, s, lat, rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL arith%0d_ready: got %b want 1", i, rdy); end
      checks++; if (lat != STAGES) begin failures++; $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, STAGES); end
      checks++; if (d !== tv[i].d) begin failures++; $display("FAIL arith%0d_data: got %h want %h", i, d, tv[i].d); end
      checks++; if (f !== tv[i].f) begin failures++; $display("FAIL arith%0d_flags: got %b want %b", i, f, tv[i].f); end
      checks++; if (t !== tv[i].tag) begin failures++; $display("FAIL arith%0d_tag: got %h want %h", i, t, tv[i].tag); end
      checks++; if (s !== tv[i].s) begin failures++; $display("FAIL arith%0d_sat: got %b want %b", i, s, tv[i].s); end
    end
  endtask

  task automatic test_saturation;
    vec_t tv [4] = '{
      '{2'b00, 32'h7FFFFFFF, 32'h00000001, 4'h1, 32'h80000000, 4'b0101, 1'b0},
      '{2'b10, 32'h7FFFFFFF, 32'h00000001, 4'h2, SAT ? 32'h7FFFFFFF : 32'h80000000, 4'b0101, SAT},
      '{2'b11, 32'h80000000, 32'h00000001, 4'h3, SAT ? 32'h80000000 : 32'h7FFFFFFF, 4'b0011, SAT},
      '{2'b10, 32'h80000000, 32'hFFFFFFFF, 4'h4, SAT ? 32'h80000000 : 32'h7FFFFFFF, 4'b0011, SAT}
    };
    logic [31:0] d; logic [3:0] f, t; logic s, rdy; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].tag, d, f, t, s, lat, rdy);
      checks++; if (lat != STAGES) begin failures++; $display("FAIL sat%0d_latency: got %0d want %0d", i, lat, STAGES); end
      checks++; if (d !== tv[i].d) begin failures++; $display("FAIL sat%0d_data: got %h want %h", i, d, tv[i].d); end
      checks++; if (f !== tv[i].f) begin failures++; $display("FAIL sat%0d_flags: got %b want %b", i, f, tv[i].f); end
      checks++; if (t !== tv[i].tag) begin failures++; $display("FAIL sat%0d_tag: got %h want %h", i, t, tv[i].tag); end
      checks++; if (s !== tv[i].s) begin failures++; $display("FAIL sat%0d_flag_sat: got %b want %b", i, s, tv[i].s); end
    end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    logic [31:0] exp_d;
    for (int c = 0; c < 14; c++) begin
      out_ready = 1'b1;
      if (c < 8) begin
        in_valid = 1'b1; in_op = 2'b00; in_tag = c[3:0];
        in_a = 32'h000000F0 + 32'(c * 16); in_b = 32'h00000010;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready c%0d: got %b want 1", c, in_ready); end
      end
      @(posedge clk); #1;
      if (out_valid) begin
        exp_d = 32'h00000100 + 32'(got * 16);
        checks++; if (out_tag !== got[3:0]) begin failures++; $display("FAIL b2b_tag%0d: got %h want %h", got, out_tag, got[3:0]); end
        checks++; if (out_data !== exp_d) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", got, out_data, exp_d); end
        checks++; if (c != got + STAGES - 1) begin failures++; $display("FAIL b2b_cycle%0d: got %0d want %0d", got, c, got + STAGES - 1); end
        got++;
      end
    end
    checks++; if (got != 8) begin failures++; $display("FAIL b2b_count: got %0d want 8", got); end
  endtask

  task automatic test_stall;
    int acc = 0;
    logic [31:0] exp_d;
    for (int c = 0; c < 16; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'h100 * (c + 1); in_b = 32'h1;
        in_tag = 4'(c + 8); out_ready = 1'b1;
      end else if (c < 8) begin
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'h500; in_b = 32'h1;
        in_tag = 4'hC; out_ready = (c == 7);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (c >= 4 && c < 7) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready c%0d: got %b want 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c%0d: got %b want 1", c, out_valid); end
        checks++; if (out_tag !== 4'h8) begin failures++; $display("FAIL stall_tag c%0d: got %h want 8", c, out_tag); end
        checks++; if (out_data !== 32'h101) begin failures++; $display("FAIL stall_data c%0d: got %h want 00000101", c, out_data); end
      end
      if (out_valid && out_ready) begin
        if (acc < 5) begin
          exp_d = 32'h100 * (acc + 1) + 32'h1;
          checks++; if (out_tag !== 4'(acc + 8)) begin failures++; $display("FAIL stall_order_tag%0d: got %h want %h", acc, out_tag, 4'(acc + 8)); end
          checks++; if (out_data !== exp_d) begin failures++; $display("FAIL stall_order_data%0d: got %h want %h", acc, out_data, exp_d); end
        end
        acc++;
      end
      @(posedge clk); #1;
    end
    checks++; if (acc != 5) begin failures++; $display("FAIL stall_count: got %0d want 5", acc); end
  endtask

  task automatic test_reset_inflight;
    logic [31:0] d; logic [3:0] f, t; logic s, rdy; int lat;
    int ghost = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_op = 2'b01; in_a = 32'h2000 + 32'(c); in_b = 32'h1; in_tag = c[3:0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstfl_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstfl_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rstfl_data: got %h want 0", out_data); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL rstfl_tag: got %h want 0", out_tag); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) ghost++;
    end
    checks++; if (ghost != 0) begin failures++; $display("FAIL rstfl_ghost: got %0d outputs want 0", ghost); end
    run_op(2'b01, 32'h00001000, 32'h00000001, 4'hA, d, f, t, s, lat, rdy);
    checks++; if (lat != STAGES) begin failures++; $display("FAIL rstfl_latency: got %0d want %0d", lat, STAGES); end
    checks++; if (d !== 32'h00000FFF) begin failures++; $display("FAIL rstfl_data_after: got %h want 00000fff", d); end
    checks++; if (t !== 4'hA) begin failures++; $display("FAIL rstfl_tag_after: got %h want a", t); end
    checks++; if (f !== 4'b0010) begin failures++; $display("FAIL rstfl_flags_after: got %b want 0010", f); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_saturation();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
